cq_viola_jtag_cmd_sync: RTL



---
 rtl/cq_viola_jtag_cmd_sync.sv | 131 +++++++++++++
 1 files changed

// File: rtl/cq_viola_jtag_cmd_sync.sv
// System-clock side of the JTAG debug command path: synchronises the TCK update
// strobes, captures IR/DR, and issues one-cycle per-instruction action pulses.
module cq_viola_jtag_cmd_sync #(
  parameter int IR_W        = 2,
  parameter int DR_W        = 38,
  parameter int SYNC_STAGES = 2,
  parameter int ACT_BIT     = 34
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  vs_udr,
  input  logic                  vs_uir,
  input  logic [IR_W-1:0]       ir_in,
  input  logic [DR_W-1:0]       sr,
  input  logic                  cmd_ready,
  output logic [DR_W-1:0]       jdo,
  output logic [(2**IR_W)-1:0]  take_action,
  output logic [(2**IR_W)-1:0]  take_no_action,
  output logic                  cmd_pending,
  output logic                  overrun,
  output logic [7:0]            cmd_count
);

  localparam int NUM_CMD  = 2**IR_W;
  localparam int MASK_MAX = SYNC_STAGES + 1;
  localparam int MASK_W   = $clog2(MASK_MAX + 1);

  typedef enum logic {IDLE, PEND} state_t;

  logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q;
  logic                   udr_prev_q, uir_prev_q;
  logic [MASK_W-1:0]      mask_cnt_q;
  logic                   strobe_en, udr_edge, uir_edge;

  state_t                 state_q, state_d;
  logic [DR_W-1:0]        jdo_q, jdo_d;
  logic [IR_W-1:0]        ir_q, ir_d;
  logic                   overrun_q, overrun_d;
  logic [7:0]             count_q, count_d;
  logic [NUM_CMD-1:0]     act_q, act_d, noact_q, noact_d;
  logic [NUM_CMD-1:0]     onehot;
  logic                   pend_live, issue;

  // Strobe synchronisers plus a post-reset mask so a level that is already
  // high when reset releases is never mistaken for a fresh update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync_q <= '0;
      uir_sync_q <= '0;
      udr_prev_q <= 1'b0;
      uir_prev_q <= 1'b0;
      mask_cnt_q <= '0;
    end else begin
      udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
      uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
      udr_prev_q <= udr_sync_q[SYNC_STAGES-1];
      uir_prev_q <= uir_sync_q[SYNC_STAGES-1];
      if (mask_cnt_q != MASK_W'(MASK_MAX)) mask_cnt_q <= mask_cnt_q + 1'b1;
    end
  end

  assign strobe_en = (mask_cnt_q == MASK_W'(MASK_MAX));
  assign udr_edge  = strobe_en & udr_sync_q[SYNC_STAGES-1] & ~udr_prev_q;
  assign uir_edge  = strobe_en & uir_sync_q[SYNC_STAGES-1] & ~uir_prev_q;

  assign onehot    = NUM_CMD'(1) << ir_q;
  assign pend_live = (state_q == PEND) && !uir_edge;
  assign issue     = pend_live && cmd_ready;

  // Cancel is applied first, then issue, then capture, so a same-cycle
  // issue frees the slot for the incoming command.
  always_comb begin
    state_d   = state_q;
    jdo_d     = jdo_q;
    ir_d      = ir_q;
    overrun_d = overrun_q;
    count_d   = count_q;
    act_d     = '0;
    noact_d   = '0;
    if (uir_edge) begin
      overrun_d = 1'b0;
      state_d   = IDLE;
    end
    if (issue) begin
      if (jdo_q[ACT_BIT]) act_d = onehot;
      else                noact_d = onehot;
      count_d = count_q + 8'd1;
      state_d = IDLE;
    end
    if (udr_edge) begin
      if (pend_live && !issue) begin
        overrun_d = 1'b1;
      end else begin
        jdo_d   = sr;
        ir_d    = ir_in;
        state_d = PEND;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jdo_q     <= '0;
      ir_q      <= '0;
      overrun_q <= 1'b0;
      count_q   <= 8'd0;
      act_q     <= '0;
      noact_q   <= '0;
    end else begin
      jdo_q     <= jdo_d;
      ir_q      <= ir_d;
      overrun_q <= overrun_d;
      count_q   <= count_d;
      act_q     <= act_d;
      noact_q   <= noact_d;
    end
  end

  assign jdo            = jdo_q;
  assign take_action    = act_q;
  assign take_no_action = noact_q;
  assign cmd_pending    = (state_q == PEND);
  assign overrun        = overrun_q;
  assign cmd_count      = count_q;

endmodule
